// File: rtl/conv_1st_pkg.sv
// Shared sizing for the first conv layer's post-processing stages.
// Defaults match one conv_1st_top output frame.
package conv_1st_pkg;
    localparam int DW         = 8;
    localparam int LANES      = 40;
    localparam int ROWS       = 28;
    localparam int CH_NUM     = 32;
    localparam int POOL_LANES = LANES / 2;
endpackage

// File: rtl/conv_1st_relu_max2.sv
// Lane cell: max(relu(a), relu(b)). Used for both the horizontal and the
// vertical pooling compare.
module conv_1st_relu_max2
    import conv_1st_pkg::*;
#(
    parameter int DW = conv_1st_pkg::DW
) (
    input  logic signed [DW-1:0] i_a,
    input  logic signed [DW-1:0] i_b,
    output logic        [DW-1:0] o_max
);

    function automatic logic [DW-1:0] relu(input logic signed [DW-1:0] x);
        return x[DW-1] ? '0 : x;
    endfunction

    logic [DW-1:0] w_ra;
    logic [DW-1:0] w_rb;

    assign w_ra = relu(i_a);
    assign w_rb = relu(i_b);
    // Both operands are non-negative here, so an unsigned compare is exact.
    assign o_max = (w_ra >= w_rb) ? w_ra : w_rb;

endmodule

// File: rtl/conv_1st_relu_pool.sv
// ReLU + 2x2 max-pool over the conv_1st row stream: lane pairs horizontally,
// consecutive rows of a channel map vertically. One pooled row per two rows.
module conv_1st_relu_pool
    import conv_1st_pkg::*;
#(
    parameter int DW     = conv_1st_pkg::DW,
    parameter int LANES  = conv_1st_pkg::LANES,
    parameter int ROWS   = conv_1st_pkg::ROWS,
    parameter int CH_NUM = conv_1st_pkg::CH_NUM
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [LANES*DW-1:0]         conv_i,
    input  logic                        valid_i,
    output logic [(LANES/2)*DW-1:0]     pool_o,
    output logic                        valid_o,
    output logic [$clog2(CH_NUM)-1:0]   ch_o,
    output logic                        frame_done_o
);

    localparam int OUT_LANES = LANES / 2;
    localparam int ROW_W     = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CH_W      = $clog2(CH_NUM);
    localparam bit ODD_ROWS  = (ROWS % 2) == 1;
    localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(ROWS - 1);
    localparam logic [ROW_W-1:0] PAIR_LAST = ROW_W'(ROWS - 1 - (ROWS % 2));
    localparam logic [CH_W-1:0]  CH_LAST   = CH_W'(CH_NUM - 1);

    logic [OUT_LANES-1:0][DW-1:0] w_h_p0;
    logic [OUT_LANES-1:0][DW-1:0] w_v_p0;
    logic [OUT_LANES-1:0][DW-1:0] r_buf;
    logic                         r_phase;
    logic [ROW_W-1:0]             r_row;
    logic [CH_W-1:0]              r_ch;
    logic                         w_row_last;
    logic                         w_pair_last;
    logic                         w_ch_last;
    logic                         w_drop;

    logic [OUT_LANES-1:0][DW-1:0] r_pool_p1;
    logic                         r_vld_p1;
    logic [CH_W-1:0]              r_ch_p1;
    logic                         r_done_p1;

    // Stage p0: combinational ReLU + horizontal max, then vertical max vs buffer
    for (genvar j = 0; j < OUT_LANES; j++) begin : g_lane
        conv_1st_relu_max2 #(.DW(DW)) u_hmax (
            .i_a   (conv_i[(2*j)*DW +: DW]),
            .i_b   (conv_i[(2*j+1)*DW +: DW]),
            .o_max (w_h_p0[j])
        );
        conv_1st_relu_max2 #(.DW(DW)) u_vmax (
            .i_a   (r_buf[j]),
            .i_b   (w_h_p0[j]),
            .o_max (w_v_p0[j])
        );
    end

    assign w_row_last  = (r_row == ROW_LAST);
    assign w_pair_last = (r_row == PAIR_LAST);
    assign w_ch_last   = (r_ch == CH_LAST);
    // With an odd row count the final row of each map has no partner.
    assign w_drop      = ODD_ROWS && w_row_last;

    // Stage p1: output register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_buf     <= '0;
            r_phase   <= 1'b0;
            r_row     <= '0;
            r_ch      <= '0;
            r_pool_p1 <= '0;
            r_vld_p1  <= 1'b0;
            r_ch_p1   <= '0;
            r_done_p1 <= 1'b0;
        end else begin
            r_vld_p1  <= 1'b0;
            r_done_p1 <= 1'b0;
            if (valid_i) begin
                if (w_row_last) begin
                    r_row <= '0;
                    r_ch  <= w_ch_last ? '0 : r_ch + 1'b1;
                end else begin
                    r_row <= r_row + 1'b1;
                end

                if (w_drop) begin
                    r_phase <= 1'b0;
                end else if (!r_phase) begin
                    r_buf   <= w_h_p0;
                    r_phase <= 1'b1;
                end else begin
                    r_pool_p1 <= w_v_p0;
                    r_vld_p1  <= 1'b1;
                    r_ch_p1   <= r_ch;
                    r_done_p1 <= w_pair_last && w_ch_last;
                    r_phase   <= 1'b0;
                end
            end
        end
    end

    assign pool_o       = r_pool_p1;
    assign valid_o      = r_vld_p1;
    assign ch_o         = r_ch_p1;
    assign frame_done_o = r_done_p1;

endmodule

// File: tb/tb_conv_1st_relu_pool.sv
// Directed bench for conv_1st_relu_pool: default-size instance plus a
// ROWS=3 / CH_NUM=2 instance for the odd-row and short-frame cases.
module tb_conv_1st_relu_pool;

    logic         clk = 1'b0;
    logic         rst;
    logic [319:0] c0, c1;
    logic         v0, v1;
    logic [159:0] p0, p1;
    logic         vo0, vo1;
    logic [4:0]   ch0;
    logic [0:0]   ch1;
    logic         fd0, fd1;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    conv_1st_relu_pool dut0 (
        .clk(clk), .rst(rst), .conv_i(c0), .valid_i(v0),
        .pool_o(p0), .valid_o(vo0), .ch_o(ch0), .frame_done_o(fd0)
    );

    conv_1st_relu_pool #(.DW(8), .LANES(40), .ROWS(3), .CH_NUM(2)) dut1 (
        .clk(clk), .rst(rst), .conv_i(c1), .valid_i(v1),
        .pool_o(p1), .valid_o(vo1), .ch_o(ch1), .frame_done_o(fd1)
    );

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [319:0] fill320(input logic [7:0] v);
        logic [319:0] r;
        for (int k = 0; k < 40; k++) r[k*8 +: 8] = v;
        return r;
    endfunction

    function automatic logic [159:0] fill160(input logic [7:0] v);
        logic [159:0] r;
        for (int k = 0; k < 20; k++) r[k*8 +: 8] = v;
        return r;
    endfunction

    function automatic logic [319:0] alt320(input logic [7:0] ev, input logic [7:0] od);
        logic [319:0] r;
        for (int k = 0; k < 40; k++) r[k*8 +: 8] = (k % 2 == 0) ? ev : od;
        return r;
    endfunction

    task automatic reset_all();
        @(negedge clk);
        rst = 1'b1; v0 = 1'b0; v1 = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Two back-to-back rows into dut0; returns at the negedge where the result is visible.
    task automatic pair0(input logic [319:0] a, input logic [319:0] b);
        @(negedge clk); c0 = a; v0 = 1'b1;
        @(negedge clk); c0 = b;
        @(negedge clk); v0 = 1'b0;
    endtask

    logic [319:0] rowa, rowb;
    logic [159:0] e_basic;
    logic [7:0]   vals [6] = '{8'd1, 8'd2, 8'd100, 8'd3, 8'd4, 8'd100};
    logic [159:0] got1 [2];
    logic [0:0]   gch1 [2];
    logic         gfd1 [2];
    int n1, gapv, pulses, ch_bad, pool_bad, dones, done_idx;

    initial begin
        rst = 1'b1; v0 = 1'b0; v1 = 1'b0; c0 = '0; c1 = '0;
        repeat (3) @(negedge clk);
        check("rst_pool", p0, 0);
        check("rst_valid", vo0, 0);
        check("rst_ch", ch0, 0);
        check("rst_done", fd0, 0);
        rst = 1'b0;

        for (int k = 0; k < 40; k++) begin
            rowa[k*8 +: 8] = 8'(k);
            rowb[k*8 +: 8] = 8'(40 - k);
        end
        for (int j = 0; j < 20; j++)
            e_basic[j*8 +: 8] = (2*j + 1 > 40 - 2*j) ? 8'(2*j + 1) : 8'(40 - 2*j);

        // basic back-to-back pair
        @(negedge clk); c0 = rowa; v0 = 1'b1;
        @(negedge clk);
        check("basic_no_early", vo0, 0);
        c0 = rowb;
        @(negedge clk); v0 = 1'b0;
        check("basic_valid", vo0, 1);
        check("basic_pool", p0, e_basic);
        check("basic_ch", ch0, 0);
        check("basic_done", fd0, 0);
        @(negedge clk);
        check("basic_pulse", vo0, 0);
        check("basic_hold", p0, e_basic);

        // gap of 5 idle cycles between rows
        @(negedge clk); c0 = rowa; v0 = 1'b1;
        @(negedge clk); v0 = 1'b0;
        gapv = int'(vo0);
        repeat (5) begin
            @(negedge clk);
            if (vo0) gapv++;
        end
        check("gap_no_valid", gapv, 0);
        check("gap_hold", p0, e_basic);
        c0 = rowb; v0 = 1'b1;
        @(negedge clk); v0 = 1'b0;
        check("gap_valid", vo0, 1);
        check("gap_pool", p0, e_basic);

        // ReLU cases
        pair0(fill320(8'h80), fill320(8'h80));
        check("relu_neg_valid", vo0, 1);
        check("relu_neg_pool", p0, 0);
        pair0(alt320(8'hFB, 8'd7), alt320(8'd7, 8'hFB));
        check("relu_mixed_pool", p0, fill160(8'd7));
        pair0(fill320(8'hFF), alt320(8'h01, 8'h81));
        check("relu_unsigned_pool", p0, fill160(8'd1));
        check("relu_ch", ch0, 0);

        // odd ROWS=3, CH_NUM=2 on dut1
        n1 = 0;
        for (int b = 0; b < 8; b++) begin
            @(negedge clk);
            if (vo1) begin
                if (n1 < 2) begin
                    got1[n1] = p1; gch1[n1] = ch1; gfd1[n1] = fd1;
                end
                n1++;
            end
            if (b < 6) begin c1 = fill320(vals[b]); v1 = 1'b1; end
            else v1 = 1'b0;
        end
        check("odd_count", n1, 2);
        check("odd_pool0", got1[0], fill160(8'd2));
        check("odd_ch0", gch1[0], 0);
        check("odd_done0", gfd1[0], 0);
        check("odd_pool1", got1[1], fill160(8'd4));
        check("odd_ch1", gch1[1], 1);
        check("odd_done1", gfd1[1], 1);

        // full default frame: 896 beats, lane value = row index within its map
        reset_all();
        pulses = 0; ch_bad = 0; pool_bad = 0; dones = 0; done_idx = -1;
        for (int b = 0; b < 898; b++) begin
            @(negedge clk);
            if (vo0) begin
                if (ch0 != 5'(pulses / 14)) ch_bad++;
                if (p0 != fill160(8'(2 * (pulses % 14) + 1))) pool_bad++;
                pulses++;
                if (fd0) begin dones++; done_idx = pulses; end
            end else if (fd0) begin
                dones++;
            end
            if (b < 896) begin c0 = fill320(8'(b % 28)); v0 = 1'b1; end
            else v0 = 1'b0;
        end
        check("frame_pulses", pulses, 448);
        check("frame_ch_seq", ch_bad, 0);
        check("frame_pool_seq", pool_bad, 0);
        check("frame_done_count", dones, 1);
        check("frame_done_at_last", done_idx, 448);
        pair0(fill320(8'd3), fill320(8'd6));
        check("wrap_valid", vo0, 1);
        check("wrap_ch", ch0, 0);
        check("wrap_done", fd0, 0);
        check("wrap_pool", p0, fill160(8'd6));

        // reset mid-map, with valid_i high during reset
        @(negedge clk); c0 = fill320(8'd100); v0 = 1'b1;
        @(negedge clk); rst = 1'b1; c0 = fill320(8'd120);
        @(negedge clk); rst = 1'b0;
        check("midrst_valid", vo0, 0);
        check("midrst_pool", p0, 0);
        c0 = fill320(8'd9);
        @(negedge clk);
        check("midrst_no_pair", vo0, 0);
        c0 = fill320(8'd5);
        @(negedge clk); v0 = 1'b0;
        check("midrst_out_valid", vo0, 1);
        check("midrst_out_pool", p0, fill160(8'd9));
        check("midrst_out_ch", ch0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
